qam_demap_pack: RTL and testbench

Parametrised hard-decision demapper that generalises the fixed 16-QAM demapper to BPSK, QPSK, 16-QAM and 64-QAM, selected per symbol. It sits after the FFT/equaliser output stage. It packs the variable number of decided bits per symbol into fixed OUT_W-bit words behind a valid/ready handshake, with a last-symbol flush, for the downstream deinterleaver.

---
 rtl/qam_demap_pack_if.sv | 40 ++++
 rtl/qam_demap_pack.sv | 196 +++++++++++++++++++
 tb/tb_qam_demap_pack.sv | 294 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/qam_demap_pack_if.sv
// qam_demap_pack_if
//   Bundles the symbol input stream, the packed-word output stream and the
//   sticky error flag of qam_demap_pack.
//   master : upstream/downstream side (drives symbols and o_ready)
//   slave  : the demapper/packer itself
//   Signals:
//     i_valid/i_ready         symbol handshake
//     i_re/i_im  [DATA_W]     signed equalised symbol
//     i_mode     [2]          0 BPSK, 1 QPSK, 2 16-QAM, 3 64-QAM
//     i_last                  final symbol of a packet
//     o_valid/o_ready         packed word handshake
//     o_data     [OUT_W]      packed bits, first decided bit in the MSB
//     o_last                  final word of a packet
//     o_err                   sticky unsupported-mode flag
interface qam_demap_pack_if #(
  parameter int DATA_W = 16,
  parameter int OUT_W  = 8
);
  logic                     i_valid;
  logic                     i_ready;
  logic signed [DATA_W-1:0] i_re;
  logic signed [DATA_W-1:0] i_im;
  logic [1:0]               i_mode;
  logic                     i_last;
  logic                     o_valid;
  logic                     o_ready;
  logic [OUT_W-1:0]         o_data;
  logic                     o_last;
  logic                     o_err;

  modport master (
    output i_valid, i_re, i_im, i_mode, i_last, o_ready,
    input  i_ready, o_valid, o_data, o_last, o_err
  );

  modport slave (
    input  i_valid, i_re, i_im, i_mode, i_last, o_ready,
    output i_ready, o_valid, o_data, o_last, o_err
  );
endinterface

// File: rtl/qam_demap_pack.sv
// qam_demap_pack
//   Hard-decision demapper for BPSK / QPSK / 16-QAM / 64-QAM (mode chosen per
//   symbol) that packs the variable number of decided bits into OUT_W-bit
//   words with a valid/ready output and a last-symbol flush.
//   Parameters: DATA_W (input width), UNIT_T (amplitude of the +-1 point),
//               OUT_W (packed word width, >= 6).
//   Ports: clk, rst (asynchronous, active high), bus (qam_demap_pack_if.slave).
//   Build option: define QAM64_EN to demap mode 3 as 64-QAM. Without it,
//   mode-3 symbols are consumed, append no bits and set the sticky o_err.
module qam_demap_pack #(
  parameter int DATA_W = 16,
  parameter int UNIT_T = 1024,
  parameter int OUT_W  = 8
) (
  input logic             clk,
  input logic             rst,
  qam_demap_pack_if.slave bus
);

  // The accumulator never holds more than OUT_W-1 bits plus one 6-bit symbol.
  localparam int ACC_W = OUT_W + 5;
  localparam int CNT_W = $clog2(ACC_W + 1);
  // Two guard bits so that negating the most negative input cannot overflow.
  localparam int EXT_W = DATA_W + 2;
  localparam logic signed [EXT_W-1:0] T2      = EXT_W'(2 * UNIT_T);
  localparam logic [CNT_W-1:0]        OUT_W_C = CNT_W'(OUT_W);

`ifdef QAM64_EN
  localparam logic signed [EXT_W-1:0] T4 = EXT_W'(4 * UNIT_T);
  localparam int AX_W = 4;
`else
  localparam int AX_W = 2;
`endif
  // Per-axis decision vector layout: [AX_SIGN] x>=0, [AX_LT2] |x|<2T,
  // and with 64-QAM also [1] |x|<4T, [0] abs(|x|-4T)<2T.
  localparam int AX_SIGN = AX_W - 1;
  localparam int AX_LT2  = AX_W - 2;

  logic [AX_W-1:0] axis_bits [2];

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_axis
      logic signed [DATA_W-1:0] x;
      logic signed [EXT_W-1:0]  x_ext;
      logic signed [EXT_W-1:0]  mag;

      assign x     = (gi == 0) ? bus.i_re : bus.i_im;
      assign x_ext = {{2{x[DATA_W-1]}}, x};
      assign mag   = x_ext[EXT_W-1] ? -x_ext : x_ext;
`ifdef QAM64_EN
      logic signed [EXT_W-1:0] dist;
      logic signed [EXT_W-1:0] dist_mag;
      assign dist     = mag - T4;
      assign dist_mag = dist[EXT_W-1] ? -dist : dist;
      assign axis_bits[gi] = {~x_ext[EXT_W-1], mag < T2, mag < T4, dist_mag < T2};
`else
      assign axis_bits[gi] = {~x_ext[EXT_W-1], mag < T2};
`endif
    end
  endgenerate

  // Symbol bits right-aligned, first decided bit at position sym_n-1.
  logic [5:0] sym_bits;
  logic [2:0] sym_n;
  logic       sym_bad;

  always_comb begin
    sym_bits = '0;
    sym_n    = '0;
    sym_bad  = 1'b0;
    case (bus.i_mode)
      2'd0: begin
        sym_bits = {5'b0, axis_bits[0][AX_SIGN]};
        sym_n    = 3'd1;
      end
      2'd1: begin
        sym_bits = {4'b0, axis_bits[0][AX_SIGN], axis_bits[1][AX_SIGN]};
        sym_n    = 3'd2;
      end
      2'd2: begin
        sym_bits = {2'b0, axis_bits[0][AX_SIGN], axis_bits[0][AX_LT2],
                    axis_bits[1][AX_SIGN], axis_bits[1][AX_LT2]};
        sym_n    = 3'd4;
      end
      default: begin
`ifdef QAM64_EN
        sym_bits = {axis_bits[0][3], axis_bits[0][1], axis_bits[0][0],
                    axis_bits[1][3], axis_bits[1][1], axis_bits[1][0]};
        sym_n    = 3'd6;
`else
        sym_bad  = 1'b1;
`endif
      end
    endcase
  end

  // Valid bits live in acc_reg[cnt_reg-1:0], oldest at the top. Stale bits
  // above cnt_reg are never read: extraction is always bounded by cnt_reg.
  logic [ACC_W-1:0] acc_reg, acc_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic             flush_pend_reg, flush_pend_next;
  logic             o_valid_reg, o_valid_next;
  logic [OUT_W-1:0] o_data_reg, o_data_next;
  logic             o_last_reg, o_last_next;
  logic             o_err_reg, o_err_next;

  logic             i_ready_int;
  logic             accept;
  logic             out_free;
  logic             do_xfer;
  logic             do_flush;
  logic [OUT_W-1:0] xfer_word;
  logic [OUT_W-1:0] flush_word;

  assign i_ready_int = (cnt_reg < OUT_W_C) && !flush_pend_reg;
  assign accept      = bus.i_valid && i_ready_int;
  assign out_free    = !o_valid_reg || bus.o_ready;
  assign do_xfer     = (cnt_reg >= OUT_W_C) && out_free;
  assign do_flush    = flush_pend_reg && (cnt_reg != '0) && (cnt_reg < OUT_W_C) && out_free;
  // Oldest OUT_W bits for a full word; remaining bits MSB-aligned, zero-padded.
  assign xfer_word   = OUT_W'(acc_reg >> (cnt_reg - OUT_W_C));
  assign flush_word  = OUT_W'(acc_reg << (OUT_W_C - cnt_reg));

  // accept, do_xfer and do_flush are mutually exclusive by construction:
  // accept needs cnt<OUT_W and no pending flush.
  always_comb begin
    acc_next        = acc_reg;
    cnt_next        = cnt_reg;
    flush_pend_next = flush_pend_reg;
    o_valid_next    = o_valid_reg;
    o_data_next     = o_data_reg;
    o_last_next     = o_last_reg;
    o_err_next      = o_err_reg;

    if (o_valid_reg && bus.o_ready) begin
      o_valid_next = 1'b0;
    end

    if (accept) begin
      acc_next = (acc_reg << sym_n) | ACC_W'(sym_bits);
      cnt_next = cnt_reg + CNT_W'(sym_n);
      if (bus.i_last) begin
        flush_pend_next = 1'b1;
      end
      if (sym_bad) begin
        o_err_next = 1'b1;
      end
    end else if (do_xfer) begin
      o_valid_next = 1'b1;
      o_data_next  = xfer_word;
      o_last_next  = flush_pend_reg && (cnt_reg == OUT_W_C);
      cnt_next     = cnt_reg - OUT_W_C;
      // A word that empties the accumulator of a flushing packet ends it.
      if (flush_pend_reg && (cnt_reg == OUT_W_C)) begin
        flush_pend_next = 1'b0;
      end
    end else if (do_flush) begin
      o_valid_next    = 1'b1;
      o_data_next     = flush_word;
      o_last_next     = 1'b1;
      cnt_next        = '0;
      flush_pend_next = 1'b0;
    end else if (flush_pend_reg && (cnt_reg == '0)) begin
      // Nothing left to send (e.g. last symbol appended no bits).
      flush_pend_next = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_reg        <= '0;
      cnt_reg        <= '0;
      flush_pend_reg <= 1'b0;
      o_valid_reg    <= 1'b0;
      o_data_reg     <= '0;
      o_last_reg     <= 1'b0;
      o_err_reg      <= 1'b0;
    end else begin
      acc_reg        <= acc_next;
      cnt_reg        <= cnt_next;
      flush_pend_reg <= flush_pend_next;
      o_valid_reg    <= o_valid_next;
      o_data_reg     <= o_data_next;
      o_last_reg     <= o_last_next;
      o_err_reg      <= o_err_next;
    end
  end

  assign bus.i_ready = i_ready_int;
  assign bus.o_valid = o_valid_reg;
  assign bus.o_data  = o_data_reg;
  assign bus.o_last  = o_last_reg;
  assign bus.o_err   = o_err_reg;

endmodule

// File: tb/tb_qam_demap_pack.sv
// tb_qam_demap_pack
//   Self-checking bench for qam_demap_pack: directed constellation and
//   boundary cases, backpressure, unsupported mode, mid-word reset and a
//   randomized run checked against a bit-queue reference model.
`timescale 1ns/1ps
module tb_qam_demap_pack;
  localparam int DATA_W = 16;
  localparam int UNIT_T = 1024;
  localparam int OUT_W  = 8;
  localparam int T      = UNIT_T;

  typedef struct {
    logic [OUT_W-1:0] d;
    logic             l;
  } word_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  qam_demap_pack_if #(.DATA_W(DATA_W), .OUT_W(OUT_W)) bus ();

  qam_demap_pack #(.DATA_W(DATA_W), .UNIT_T(UNIT_T), .OUT_W(OUT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int     checks = 0;
  int     errors = 0;
  bit     bits_q [$];
  word_t  exp_q  [$];
  bit     exp_err    = 1'b0;
  bit     rand_ready = 1'b0;
  bit     hold_v     = 1'b0;
  logic [OUT_W-1:0] hold_d;
  logic             hold_l;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int iabs(input int v);
    return (v < 0) ? -v : v;
  endfunction

  // Pops up to OUT_W bits, first bit into the MSB, zero-padded.
  task automatic model_emit(input bit last);
    word_t w;
    w.d = '0;
    for (int k = 0; k < OUT_W; k++) begin
      w.d = w.d << 1;
      if (bits_q.size() > 0) w.d[0] = bits_q.pop_front();
    end
    w.l = last;
    exp_q.push_back(w);
  endtask

  task automatic model_accept(input int re, input int im, input int mode, input bit last);
    int v [2];
    v[0] = re;
    v[1] = im;
    case (mode)
      0: bits_q.push_back(re >= 0);
      1: begin
        bits_q.push_back(re >= 0);
        bits_q.push_back(im >= 0);
      end
      2: for (int a = 0; a < 2; a++) begin
        bits_q.push_back(v[a] >= 0);
        bits_q.push_back(iabs(v[a]) < 2 * T);
      end
      default: begin
`ifdef QAM64_EN
        for (int a = 0; a < 2; a++) begin
          bits_q.push_back(v[a] >= 0);
          bits_q.push_back(iabs(v[a]) < 4 * T);
          bits_q.push_back(iabs(iabs(v[a]) - 4 * T) < 2 * T);
        end
`else
        exp_err = 1'b1;
`endif
      end
    endcase
    if (last) begin
      while (bits_q.size() >= OUT_W) model_emit(bits_q.size() == OUT_W);
      if (bits_q.size() > 0) model_emit(1'b1);
    end else begin
      while (bits_q.size() >= OUT_W) model_emit(1'b0);
    end
  endtask

  // Presents one symbol; returns at posedge+1 after it was accepted.
  task automatic send(input int re, input int im, input int mode, input bit last);
    int waited = 0;
    bus.i_valid = 1'b1;
    bus.i_re    = DATA_W'(re);
    bus.i_im    = DATA_W'(im);
    bus.i_mode  = 2'(mode);
    bus.i_last  = last;
    forever begin
      @(negedge clk);
      if (bus.i_ready) break;
      waited++;
      if (waited > 1000) break;
    end
    if (waited > 1000) begin
      check_val("send_timeout", 32'(waited), 0);
    end else begin
      model_accept(re, im, mode, last);
    end
    @(posedge clk);
    #1;
    bus.i_valid = 1'b0;
    bus.i_last  = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    bus.o_ready = 1'b1;
    while ((exp_q.size() != 0 || bus.o_valid) && n < 500) begin
      @(posedge clk);
      #1;
      n++;
    end
    check_val("drain", exp_q.size(), 0);
  endtask

  function automatic int rand_val();
    if ($urandom_range(0, 1) == 1) return int'($urandom_range(0, 65535)) - 32768;
    return (int'($urandom_range(0, 16)) - 8) * T + int'($urandom_range(0, 2)) - 1;
  endfunction

  // Output monitor: compares consumed words and checks hold-while-stalled.
  initial begin
    word_t w;
    forever begin
      @(negedge clk);
      if (rst) begin
        hold_v = 1'b0;
      end else begin
        if (hold_v) begin
          check_val("hold_valid", bus.o_valid, 1);
          check_val("hold_data", bus.o_data, hold_d);
          check_val("hold_last", bus.o_last, hold_l);
        end
        if (bus.o_valid && bus.o_ready) begin
          check_val("word_expected", exp_q.size() != 0, 1);
          if (exp_q.size() != 0) begin
            w = exp_q.pop_front();
            $display("word data %02h last %0b (exp %02h %0b)", bus.o_data, bus.o_last, w.d, w.l);
            check_val("o_data", bus.o_data, w.d);
            check_val("o_last", bus.o_last, w.l);
          end
        end
        hold_v = bus.o_valid && !bus.o_ready;
        hold_d = bus.o_data;
        hold_l = bus.o_last;
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rand_ready) bus.o_ready = 1'($urandom_range(0, 1));
    end
  end

  initial begin
    int accepted;
    bus.i_valid = 1'b0;
    bus.i_re    = '0;
    bus.i_im    = '0;
    bus.i_mode  = '0;
    bus.i_last  = 1'b0;
    bus.o_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    check_val("rst_i_ready", bus.i_ready, 1);
    check_val("rst_o_valid", bus.o_valid, 0);
    check_val("rst_o_data", bus.o_data, 0);
    check_val("rst_o_last", bus.o_last, 0);
    check_val("rst_o_err", bus.o_err, 0);

    // 16-QAM pair completing one word, with latency check.
    bus.o_ready = 1'b1;
    send(3 * T, -T, 2, 1'b0);
    send(-3 * T, T, 2, 1'b1);
    check_val("lat_early", bus.o_valid, 0);
    @(posedge clk);
    #1;
    check_val("lat_valid", bus.o_valid, 1);
    drain();

    // QPSK flush with padding.
    send(T, T, 1, 1'b0);
    send(-T, T, 1, 1'b0);
    send(T, -T, 1, 1'b1);
    drain();

    // 64-QAM I-axis sweep.
    for (int i = 0; i < 8; i++) send((2 * i - 7) * T, 7 * T, 3, i == 7);
    drain();

    // Boundary values.
    send(-32768, 32767, 2, 1'b0);
    send(0, 2 * T, 2, 1'b0);
    send(-2 * T, 2 * T - 1, 2, 1'b0);
    send(-1, -2 * T + 1, 2, 1'b0);
    send(32767, -32768, 3, 1'b1);
    drain();

    // Mode 3 in the middle of a QPSK packet.
    send(T, T, 1, 1'b0);
    send(T, -T, 3, 1'b0);
    send(-T, -T, 1, 1'b1);
    check_val("err_sticky", bus.o_err, exp_err);
    drain();

    // Backpressure with continuous BPSK.
    bus.o_ready = 1'b0;
    accepted = 0;
    for (int c = 0; c < 40; c++) begin
      int v;
      v = rand_val();
      bus.i_valid = 1'b1;
      bus.i_re    = DATA_W'(v);
      bus.i_im    = '0;
      bus.i_mode  = 2'd0;
      @(negedge clk);
      if (bus.i_ready) begin
        accepted++;
        model_accept(v, 0, 0, 1'b0);
      end
      @(posedge clk);
      #1;
    end
    bus.i_valid = 1'b0;
    check_val("bp_accepts", 32'(accepted), 16);
    check_val("bp_i_ready", bus.i_ready, 0);
    bus.o_ready = 1'b1;
    for (int i = 0; i < 5; i++) send(rand_val(), 0, 0, i == 4);
    drain();

    // Randomized run with random downstream stalls.
    rand_ready = 1'b1;
    for (int i = 0; i < 300; i++) begin
      send(rand_val(), rand_val(), int'($urandom_range(0, 3)), $urandom_range(0, 7) == 0);
    end
    send(rand_val(), rand_val(), 2, 1'b1);
    rand_ready = 1'b0;
    drain();
    check_val("err_final", bus.o_err, exp_err);

    // Reset in the middle of a word with a stalled output.
    bus.o_ready = 1'b0;
    send(3 * T, 3 * T, 2, 1'b0);
    send(-T, 3 * T, 2, 1'b0);
    send(T, -3 * T, 2, 1'b0);
    @(posedge clk);
    #1;
    check_val("pre_rst_valid", bus.o_valid, 1);
    #2;
    rst = 1'b1;
    #1;
    check_val("mid_rst_i_ready", bus.i_ready, 1);
    check_val("mid_rst_o_valid", bus.o_valid, 0);
    check_val("mid_rst_o_data", bus.o_data, 0);
    check_val("mid_rst_o_last", bus.o_last, 0);
    check_val("mid_rst_o_err", bus.o_err, 0);
    bits_q.delete();
    exp_q.delete();
    exp_err = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    bus.o_ready = 1'b1;
    for (int i = 0; i < 5; i++) send(rand_val(), rand_val(), 1, i == 4);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
